mem_copy_initiator: RTL

- Bus-master engine that drives the data memory's port (adr, d_in, mrd, mwr) from the initiator side and copies a block of 32-bit words from a source byte address to a destination byte address.
- Sits beside the processor datapath. It is used for test preload/relocation and block moves while the CPU is stalled.
- Arbitration with the CPU is external: the engine's memory outputs are muxed in while busy=1.

---
 rtl/mem_copy_initiator.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_copy_initiator.sv
// mem_copy_initiator: bus-master engine copying len 32-bit words from src_adr to dst_adr, one READ/WRITE cycle pair per word.
// Optional running checksum of the words read is enabled by defining COPY_CHECKSUM_EN.
module mem_copy_initiator #(
  parameter int LEN_W = 16,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_adr,
  input  logic [31:0]      dst_adr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      adr,
  output logic [31:0]      d_in,
  output logic             mrd,
  output logic             mwr,
  input  logic [31:0]      d_out
`ifdef COPY_CHECKSUM_EN
  ,
  output logic [31:0]      csum
`endif
);

  localparam logic [31:0] STEP_W = 32'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [31:0]      r_src_ptr;
  logic [31:0]      r_dst_ptr;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_buf;
  logic [31:0]      r_adr;
  logic             r_mrd;
  logic             r_mwr;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
`ifdef COPY_CHECKSUM_EN
  logic [31:0]      r_csum;
`endif

  logic w_misaligned;
  logic w_len_zero;
  logic w_last_word;

  assign w_misaligned = (src_adr[1:0] != 2'b00) || (dst_adr[1:0] != 2'b00);
  assign w_len_zero   = (len == '0);
  assign w_last_word  = (r_cnt == LEN_W'(1));

  // Every memory-side output is a register, so start never reaches adr/mrd/mwr combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_src_ptr <= '0;
      r_dst_ptr <= '0;
      r_cnt     <= '0;
      r_buf     <= '0;
      r_adr     <= '0;
      r_mrd     <= 1'b0;
      r_mwr     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef COPY_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_mrd <= 1'b0;
          r_mwr <= 1'b0;
          if (start) begin
            r_src_ptr <= src_adr;
            r_dst_ptr <= dst_adr;
            r_cnt     <= len;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
`ifdef COPY_CHECKSUM_EN
            r_csum    <= '0;
`endif
            if (w_misaligned) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (w_len_zero) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_adr   <= src_adr;
              r_mrd   <= 1'b1;
              r_state <= S_READ;
            end
          end
        end

        S_READ: begin
          r_buf     <= d_out;
          r_src_ptr <= r_src_ptr + STEP_W;
          r_adr     <= r_dst_ptr;
          r_mrd     <= 1'b0;
          r_mwr     <= 1'b1;
`ifdef COPY_CHECKSUM_EN
          r_csum    <= r_csum + d_out;
`endif
          r_state   <= S_WRITE;
        end

        S_WRITE: begin
          r_dst_ptr <= r_dst_ptr + STEP_W;
          r_cnt     <= r_cnt - LEN_W'(1);
          r_mwr     <= 1'b0;
          // Exit on the last word rather than at zero so a full-range count never underflows.
          if (w_last_word) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_adr   <= r_src_ptr;
            r_mrd   <= 1'b1;
            r_state <= S_READ;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_mrd   <= 1'b0;
          r_mwr   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
  assign adr  = r_adr;
  assign d_in = r_buf;
  assign mrd  = r_mrd;
  assign mwr  = r_mwr;
`ifdef COPY_CHECKSUM_EN
  assign csum = r_csum;
`endif

endmodule
